// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Framed serial transmitter (UART-style line encoder). Accepts a
//             parallel word via a valid/ready handshake and shifts it out
//             LSB-first, framed as: start (0), data bits, optional parity
//             bit, and one or two stop bits (1). Every bit is held for
//             CLKS_PER_BIT clocks.
//  Ports    : clock      - rising-edge system clock
//             clear      - synchronous, active-high reset
//             tx_data    - word to send, sampled only at acceptance
//             tx_valid   - request to send tx_data
//             tx_ready   - high when a word can be accepted (IDLE only)
//             serial_out - serial line, idles high
//             busy       - high while a frame is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS    = 1    // 1 or 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("serial_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("serial_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("serial_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("serial_tx: DATA_WIDTH must be at least 1");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_div_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);

    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_stop_last = c_cnt_w'(STOP_BITS - 1);
    localparam logic               c_odd       = (PARITY == 2);
    localparam logic               c_has_par   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_div_w-1:0]    r_div;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_serial;
    logic                  r_ready;
    logic                  r_busy;

    logic                  w_div_done;

    assign w_div_done = (r_div == c_div_last);

    // The bit counter is shared: it indexes data bits in DATA and stop bits
    // in STOP, and is returned to zero whenever either phase completes.
    // The next line level is always registered together with the state
    // change, so serial_out never depends combinationally on an input.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            if (r_state != S_IDLE) begin
                r_div <= w_div_done ? '0 : r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (tx_valid && r_ready) begin
                        r_shift   <= tx_data;
                        r_parity  <= (^tx_data) ^ c_odd;
                        r_state   <= S_START;
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                        r_serial  <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_div_done) begin
                        r_state  <= S_DATA;
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end

                S_DATA: begin
                    if (w_div_done) begin
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            if (c_has_par) begin
                                r_state  <= S_PARITY;
                                r_serial <= r_parity;
                            end else begin
                                r_state  <= S_STOP;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_serial  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_div_done) begin
                        r_state  <= S_STOP;
                        r_serial <= 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_div_done) begin
                        if (r_bit_cnt == c_stop_last) begin
                            r_state   <= S_IDLE;
                            r_bit_cnt <= '0;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_div     <= '0;
                    r_bit_cnt <= '0;
                    r_serial  <= 1'b1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = r_ready;
    assign serial_out = r_serial;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Framed serial transmitter (UART-style line encoder) for the lab series.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out LSB-first on a single line with start, optional parity, and stop bits, each held CLKS_PER_BIT clocks.
- Drives the serial stimulus side that the existing receive/storage blocks and benches consume.

Parameters:
- DATA_WIDTH, 8: bits per word.
- CLKS_PER_BIT, 4: clock cycles per serial bit. Legal range 2..65535; values below 2 are illegal and must trip an elaboration-time check.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- clock  input  1  rising-edge system clock.
- clear  input  1  synchronous, active-high reset.
- tx_data  input  DATA_WIDTH  word to send; sampled only at acceptance.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high when a word can be accepted.
- serial_out  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE on that edge.
  - serial_out=1, tx_ready=1, busy=0.
  - Bit counter and clock divider reset to 0.
  - The shift register contents are don't-care.
  - clear has priority over all other inputs, including mid-frame; the partial frame is abandoned with no further line toggles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, busy=0, serial_out=1.
  - Acceptance = tx_valid & tx_ready at a rising edge.
  - On acceptance, latch tx_data, compute the parity bit, and go to START.
- START:
  - Starts on the edge after acceptance: serial_out=0 for exactly CLKS_PER_BIT cycles.
  - tx_ready=0, busy=1 from this edge until return to IDLE.
- DATA:
  - Bits latched[0]..latched[DATA_WIDTH-1], each held CLKS_PER_BIT cycles.
  - Shift on divider terminal count (CLKS_PER_BIT-1).
- PARITY (skipped when PARITY=0):
  - One bit: XOR of the latched word for even, inverted for odd.
- STOP:
  - serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - Example, defaults: 10*4 = 40 cycles.
- Back-to-back: tx_ready is high only in IDLE.
  - Minimum spacing from the last stop cycle to the next start bit is one IDLE cycle, with serial_out=1 in that cycle.
- Input stability:
  - Changes on tx_data or tx_valid while busy are ignored.
  - tx_valid held high while busy does not queue a request; it is accepted on the first IDLE edge.
- Outputs are registered; serial_out has no combinational path from any input.
- Divider counter width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_WIDTH+1). Both wrap to 0 at the end of each bit or frame and never overflow.

Test Plan:
- Reset: hold clear=1 for 3 cycles with tx_valid=1 → serial_out=1, tx_ready=1, busy=0 throughout. No frame starts until the cycle after clear falls.
- Defaults, send 8'hA5:
  - Line sequence is 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles.
  - busy=1 and tx_ready=0 for exactly 40 cycles, then IDLE.
- PARITY=1 with 8'h07 → parity bit 1, frame 44 cycles. PARITY=2 with 8'h07 → parity bit 0.
- Input stability: accept 8'h3C, then change tx_data to 8'hFF mid-frame with tx_valid held → line carries 8'h3C. 8'hFF is accepted on the first IDLE edge after the stop bit.
- Clear mid-frame: assert clear at cycle 15 of a frame (inside DATA) → next edge serial_out=1, tx_ready=1, busy=0. A following 8'h81 transmits as a clean 40-cycle frame.
- Back-to-back: send 8'h00 then 8'hFF with tx_valid held continuously → exactly one idle-high cycle between the stop bit of the first frame and the start bit of the second. STOP_BITS=2 extends the stop high time to 8 cycles.
